// File: rtl/sdram_sched.sv
// SDRAM access scheduler: arbitrates CHR, PRG, host and auto-refresh onto a
// single-outstanding downstream command port with ready/done handshaking.
module sdram_sched #(
   parameter int ADDR_BITS     = 23,
   parameter int HOST_MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 cpu_reset,
   input  logic                 chr_req,
   input  logic                 prg_req,
   input  logic                 host_req,
   input  logic                 chr_we,
   input  logic                 prg_we,
   input  logic                 host_we,
   input  logic [ADDR_BITS-1:0] chr_addr,
   input  logic [ADDR_BITS-1:0] prg_addr,
   input  logic [ADDR_BITS-1:0] host_addr,
   input  logic [7:0]           chr_wdata,
   input  logic [7:0]           prg_wdata,
   input  logic [7:0]           host_wdata,
   output logic                 chr_ack,
   output logic                 prg_ack,
   output logic                 host_ack,
   output logic [7:0]           rdata,
   input  logic                 refresh_tick,
   output logic                 mem_valid,
   output logic                 mem_we,
   output logic                 mem_refresh,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic                 mem_ready,
   input  logic                 mem_done,
   input  logic [7:0]           mem_rdata,
   output logic [1:0]           grant_id,
   output logic                 refresh_overrun
);

   localparam int HW = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;
   localparam logic [HW-1:0] HOST_LIMIT = HW'(HOST_MAX_WAIT);

   typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
   typedef enum logic [2:0] {SEL_NONE, SEL_REFRESH, SEL_CHR, SEL_PRG, SEL_HOST} sel_t;

   state_t                state_q, state_d;
   logic                  memValid_q, memValid_d;
   logic                  memWe_q, memWe_d;
   logic                  memRefresh_q, memRefresh_d;
   logic [ADDR_BITS-1:0]  memAddr_q, memAddr_d;
   logic [7:0]            memWdata_q, memWdata_d;
   logic [1:0]            grant_q, grant_d;
   logic [2:0]            ack_q, ack_d;
   logic [7:0]            rdata_q, rdata_d;
   logic [1:0]            refreshPending_q, refreshPending_d;
   logic [HW-1:0]         hostWait_q, hostWait_d;
   logic                  refreshOverrun_q, refreshOverrun_d;

   logic                  chrEff, prgEff, hostEff, refreshDone;
   sel_t                  sel;

   // A requester being acked this cycle is masked so a held req is not re-served back-to-back.
   always_comb begin
      chrEff  = chr_req  & ~ack_q[0];
      prgEff  = prg_req  & ~ack_q[1];
      hostEff = host_req & ~ack_q[2];
      sel     = SEL_NONE;
      if (refreshPending_q >= 2'd2)                  sel = SEL_REFRESH;
      else if (chrEff)                               sel = SEL_CHR;
      else if (refreshPending_q == 2'd1)             sel = SEL_REFRESH;
      else if (hostEff && hostWait_q >= HOST_LIMIT)  sel = SEL_HOST;
      else if (prgEff)                               sel = SEL_PRG;
      else if (hostEff)                              sel = SEL_HOST;
   end

   always_comb begin
      refreshDone      = (state_q == WAIT) && mem_done && memRefresh_q;
      refreshPending_d = refreshPending_q;
      refreshOverrun_d = refreshOverrun_q;
      if (refresh_tick && !refreshDone) begin
         if (refreshPending_q == 2'd3) refreshOverrun_d = 1'b1;
         else                          refreshPending_d = refreshPending_q + 2'd1;
      end else if (!refresh_tick && refreshDone && refreshPending_q != 2'd0) begin
         refreshPending_d = refreshPending_q - 2'd1;
      end
   end

   always_comb begin
      state_d      = state_q;
      memValid_d   = memValid_q;
      memWe_d      = memWe_q;
      memRefresh_d = memRefresh_q;
      memAddr_d    = memAddr_q;
      memWdata_d   = memWdata_q;
      grant_d      = grant_q;
      ack_d        = 3'b000;
      rdata_d      = rdata_q;
      hostWait_d   = hostWait_q;
      case (state_q)
         IDLE: begin
            if (sel != SEL_NONE) begin
               state_d      = CMD;
               memValid_d   = 1'b1;
               memRefresh_d = 1'b0;
               case (sel)
                  SEL_REFRESH: begin
                     memRefresh_d = 1'b1;
                     memWe_d      = 1'b0;
                     memAddr_d    = '0;
                     memWdata_d   = '0;
                     grant_d      = 2'd3;
                  end
                  SEL_CHR: begin
                     memWe_d    = chr_we;
                     memAddr_d  = chr_addr;
                     memWdata_d = chr_wdata;
                     grant_d    = 2'd1;
                  end
                  SEL_PRG: begin
                     memWe_d    = prg_we;
                     memAddr_d  = prg_addr;
                     memWdata_d = prg_wdata;
                     grant_d    = 2'd2;
                  end
                  SEL_HOST: begin
                     memWe_d    = host_we;
                     memAddr_d  = host_addr;
                     memWdata_d = host_wdata;
                     grant_d    = 2'd3;
                  end
                  default: ;
               endcase
               if ((sel == SEL_CHR || sel == SEL_PRG) && host_req && hostWait_q < HOST_LIMIT)
                  hostWait_d = hostWait_q + HW'(1);
               if (sel == SEL_HOST)
                  hostWait_d = '0;
            end
         end
         CMD: begin
            if (mem_ready) begin
               memValid_d = 1'b0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (mem_done) begin
               rdata_d = mem_rdata;
               grant_d = 2'd0;
               state_d = IDLE;
               // Refresh owns grant code 3 as well, so memRefresh_q gates the ack.
               if (!memRefresh_q) begin
                  case (grant_q)
                     2'd1:    ack_d = 3'b001;
                     2'd2:    ack_d = 3'b010;
                     2'd3:    ack_d = 3'b100;
                     default: ack_d = 3'b000;
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge cpu_reset) begin
      if (cpu_reset) begin
         state_q          <= IDLE;
         memValid_q       <= 1'b0;
         memWe_q          <= 1'b0;
         memRefresh_q     <= 1'b0;
         memAddr_q        <= '0;
         memWdata_q       <= '0;
         grant_q          <= 2'd0;
         ack_q            <= 3'b000;
         rdata_q          <= '0;
         refreshPending_q <= 2'd0;
         hostWait_q       <= '0;
         refreshOverrun_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         memValid_q       <= memValid_d;
         memWe_q          <= memWe_d;
         memRefresh_q     <= memRefresh_d;
         memAddr_q        <= memAddr_d;
         memWdata_q       <= memWdata_d;
         grant_q          <= grant_d;
         ack_q            <= ack_d;
         rdata_q          <= rdata_d;
         refreshPending_q <= refreshPending_d;
         hostWait_q       <= hostWait_d;
         refreshOverrun_q <= refreshOverrun_d;
      end
   end

   assign mem_valid       = memValid_q;
   assign mem_we          = memWe_q;
   assign mem_refresh     = memRefresh_q;
   assign mem_addr        = memAddr_q;
   assign mem_wdata       = memWdata_q;
   assign grant_id        = grant_q;
   assign chr_ack         = ack_q[0];
   assign prg_ack         = ack_q[1];
   assign host_ack        = ack_q[2];
   assign rdata           = rdata_q;
   assign refresh_overrun = refreshOverrun_q;

endmodule

// File: tb/tb_sdram_sched.sv
// Self-checking bench for sdram_sched: a cycle table for the basic handshake
// and arbitration, plus directed sequences for starvation, refresh and reset.
module tb_sdram_sched;

   localparam int ADDR = 23;
   localparam logic [ADDR-1:0] CHR_ADDR  = 23'h000100;
   localparam logic [ADDR-1:0] PRG_ADDR  = 23'h001234;
   localparam logic [ADDR-1:0] HOST_ADDR = 23'h7ABCDE;

   logic            clk = 1'b0;
   logic            cpu_reset;
   logic            chr_req, prg_req, host_req;
   logic            chr_we, prg_we, host_we;
   logic [ADDR-1:0] chr_addr, prg_addr, host_addr;
   logic [7:0]      chr_wdata, prg_wdata, host_wdata;
   logic            chr_ack, prg_ack, host_ack;
   logic [7:0]      rdata;
   logic            refresh_tick;
   logic            mem_valid, mem_we, mem_refresh;
   logic [ADDR-1:0] mem_addr;
   logic [7:0]      mem_wdata;
   logic            mem_ready, mem_done;
   logic [7:0]      mem_rdata;
   logic [1:0]      grant_id;
   logic            refresh_overrun;

   int checks   = 0;
   int failures = 0;

   sdram_sched #(.ADDR_BITS(ADDR), .HOST_MAX_WAIT(4)) dut (
      .clk(clk), .cpu_reset(cpu_reset),
      .chr_req(chr_req), .prg_req(prg_req), .host_req(host_req),
      .chr_we(chr_we), .prg_we(prg_we), .host_we(host_we),
      .chr_addr(chr_addr), .prg_addr(prg_addr), .host_addr(host_addr),
      .chr_wdata(chr_wdata), .prg_wdata(prg_wdata), .host_wdata(host_wdata),
      .chr_ack(chr_ack), .prg_ack(prg_ack), .host_ack(host_ack),
      .rdata(rdata), .refresh_tick(refresh_tick),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_refresh(mem_refresh),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .grant_id(grant_id), .refresh_overrun(refresh_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       chrReq;
      logic       prgReq;
      logic       memReady;
      logic       memDone;
      logic [7:0] memRdata;
      logic       expValid;
      logic [2:0] expAck;
      logic [1:0] expGrant;
      logic [7:0] expRdata;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyReset();
      chr_req = 0; prg_req = 0; host_req = 0;
      refresh_tick = 0; mem_ready = 0; mem_done = 0; mem_rdata = 8'h00;
      cpu_reset = 0;
      #1 cpu_reset = 1;
      repeat (2) @(posedge clk);
      #1 cpu_reset = 0;
   endtask

   task automatic applyStimulus(input vec_t v);
      chr_req   = v.chrReq;
      prg_req   = v.prgReq;
      mem_ready = v.memReady;
      mem_done  = v.memDone;
      mem_rdata = v.memRdata;
      @(posedge clk); #1;
      checkOutput({v.name, " mem_valid"}, 32'(mem_valid), 32'(v.expValid));
      checkOutput({v.name, " acks"}, 32'({host_ack, prg_ack, chr_ack}), 32'(v.expAck));
      checkOutput({v.name, " grant_id"}, 32'(grant_id), 32'(v.expGrant));
      checkOutput({v.name, " rdata"}, 32'(rdata), 32'(v.expRdata));
   endtask

   // Waits (bounded) for the next command, then checks its fields.
   task automatic waitGrant(input string name, input logic [1:0] expGrant, input logic expRef,
                            input logic [ADDR-1:0] expAddr, input logic expWe);
      int cycles = 0;
      while (mem_valid !== 1'b1 && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput({name, " mem_valid"}, 32'(mem_valid), 32'd1);
      checkOutput({name, " grant_id"}, 32'(grant_id), 32'(expGrant));
      checkOutput({name, " mem_refresh"}, 32'(mem_refresh), 32'(expRef));
      checkOutput({name, " mem_addr"}, 32'(mem_addr), 32'(expAddr));
      checkOutput({name, " mem_we"}, 32'(mem_we), 32'(expWe));
   endtask

   // Accepts the command, waits one cycle, completes it and checks the ack pattern.
   task automatic finishOp(input string name, input logic [2:0] expAck, input logic [7:0] rd);
      mem_ready = 1; @(posedge clk); #1; mem_ready = 0;
      checkOutput({name, " valid dropped"}, 32'(mem_valid), 32'd0);
      @(posedge clk); #1;
      mem_done = 1; mem_rdata = rd;
      @(posedge clk); #1; mem_done = 0;
      checkOutput({name, " acks"}, 32'({host_ack, prg_ack, chr_ack}), 32'(expAck));
      checkOutput({name, " grant cleared"}, 32'(grant_id), 32'd0);
   endtask

   initial begin
      logic [1:0] grantSeq [6];
      chr_we = 0; prg_we = 0; host_we = 1;
      chr_addr = CHR_ADDR; prg_addr = PRG_ADDR; host_addr = HOST_ADDR;
      chr_wdata = 8'h11; prg_wdata = 8'h22; host_wdata = 8'h5A;

      //               name            chr prg rdy done rd      vld ack     gnt  rdata
      vecs.push_back('{"p32 grant",     0,  1,  1,  0, 8'h00,   1, 3'b000, 2'd2, 8'h00});
      vecs.push_back('{"p32 accept",    0,  1,  1,  0, 8'h00,   0, 3'b000, 2'd2, 8'h00});
      vecs.push_back('{"p32 wait1",     0,  0,  1,  0, 8'h00,   0, 3'b000, 2'd2, 8'h00});
      vecs.push_back('{"p32 wait2",     0,  0,  1,  0, 8'h00,   0, 3'b000, 2'd2, 8'h00});
      vecs.push_back('{"p32 done",      0,  0,  1,  1, 8'hA5,   0, 3'b010, 2'd0, 8'hA5});
      vecs.push_back('{"p32 ackend",    0,  0,  1,  0, 8'h00,   0, 3'b000, 2'd0, 8'hA5});
      vecs.push_back('{"c33 grant",     1,  1,  0,  0, 8'h00,   1, 3'b000, 2'd1, 8'hA5});
      vecs.push_back('{"c33 doneInCmd", 1,  1,  0,  1, 8'h11,   1, 3'b000, 2'd1, 8'hA5});
      vecs.push_back('{"c33 accept",    1,  1,  1,  0, 8'h00,   0, 3'b000, 2'd1, 8'hA5});
      vecs.push_back('{"c33 done",      1,  1,  0,  1, 8'h3C,   0, 3'b001, 2'd0, 8'h3C});
      vecs.push_back('{"c33 prgGrant",  1,  1,  0,  0, 8'h00,   1, 3'b000, 2'd2, 8'h3C});
      vecs.push_back('{"c33 prgAccept", 1,  1,  1,  0, 8'h00,   0, 3'b000, 2'd2, 8'h3C});
      vecs.push_back('{"c33 prgDone",   1,  1,  0,  1, 8'h77,   0, 3'b010, 2'd0, 8'h77});
      vecs.push_back('{"c33 idle",      0,  0,  0,  0, 8'h00,   0, 3'b000, 2'd0, 8'h77});

      applyReset();
      checkOutput("rst mem_valid", 32'(mem_valid), 32'd0);
      checkOutput("rst grant_id", 32'(grant_id), 32'd0);
      checkOutput("rst acks", 32'({host_ack, prg_ack, chr_ack}), 32'd0);
      checkOutput("rst rdata", 32'(rdata), 32'd0);
      checkOutput("rst mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst mem_refresh", 32'(mem_refresh), 32'd0);
      checkOutput("rst overrun", 32'(refresh_overrun), 32'd0);
      checkOutput("rst pending", 32'(dut.refreshPending_q), 32'd0);
      checkOutput("rst host_wait", 32'(dut.hostWait_q), 32'd0);

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Host starvation: CHR/PRG alternate until host has lost four grants.
      applyReset();
      grantSeq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd3};
      chr_req = 1; prg_req = 1; host_req = 1;
      for (int i = 0; i < 6; i++) begin
         logic [ADDR-1:0] a;
         logic [2:0]      ak;
         a  = (grantSeq[i] == 2'd1) ? CHR_ADDR : (grantSeq[i] == 2'd2) ? PRG_ADDR : HOST_ADDR;
         ak = (grantSeq[i] == 2'd1) ? 3'b001 : (grantSeq[i] == 2'd2) ? 3'b010 : 3'b100;
         waitGrant($sformatf("h34 g%0d", i), grantSeq[i], 1'b0, a, grantSeq[i] == 2'd3);
         if (i == 3 || i == 4) checkOutput($sformatf("h34 wait%0d", i), 32'(dut.hostWait_q), 32'd4);
         if (i == 5) begin
            checkOutput("h34 wait cleared", 32'(dut.hostWait_q), 32'd0);
            checkOutput("h34 wdata", 32'(mem_wdata), 32'h5A);
         end
         finishOp($sformatf("h34 op%0d", i), ak, 8'h40 + 8'(i));
      end
      chr_req = 0; prg_req = 0; host_req = 0;
      @(posedge clk); #1;

      // Two refresh ticks during a CHR op outrank the still-pending CHR.
      applyReset();
      chr_req = 1;
      waitGrant("r35 chr1", 2'd1, 1'b0, CHR_ADDR, 1'b0);
      refresh_tick = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      refresh_tick = 0;
      checkOutput("r35 pending2", 32'(dut.refreshPending_q), 32'd2);
      finishOp("r35 chr1", 3'b001, 8'h42);
      waitGrant("r35 ref1", 2'd3, 1'b1, '0, 1'b0);
      finishOp("r35 ref1", 3'b000, 8'h00);
      checkOutput("r35 pending1", 32'(dut.refreshPending_q), 32'd1);
      waitGrant("r35 chr2", 2'd1, 1'b0, CHR_ADDR, 1'b0);
      finishOp("r35 chr2", 3'b001, 8'h43);
      chr_req = 0;
      waitGrant("r35 ref2", 2'd3, 1'b1, '0, 1'b0);
      finishOp("r35 ref2", 3'b000, 8'h00);
      checkOutput("r35 pending0", 32'(dut.refreshPending_q), 32'd0);
      repeat (3) @(posedge clk);
      #1 checkOutput("r35 no extra op", 32'(mem_valid), 32'd0);

      // Refresh saturation while the downstream never accepts.
      applyReset();
      refresh_tick = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin
            checkOutput("o36 pending3", 32'(dut.refreshPending_q), 32'd3);
            checkOutput("o36 no overrun yet", 32'(refresh_overrun), 32'd0);
         end
      end
      refresh_tick = 0;
      checkOutput("o36 pending sat", 32'(dut.refreshPending_q), 32'd3);
      checkOutput("o36 overrun", 32'(refresh_overrun), 32'd1);
      checkOutput("o36 refresh stuck", 32'({mem_valid, mem_refresh}), 32'b11);
      mem_ready = 1; @(posedge clk); #1; mem_ready = 0;
      mem_done = 1; refresh_tick = 1;
      @(posedge clk); #1;
      mem_done = 0; refresh_tick = 0;
      checkOutput("o36 tick+done", 32'(dut.refreshPending_q), 32'd3);
      checkOutput("o36 no ack", 32'({host_ack, prg_ack, chr_ack}), 32'd0);

      // Reset in WAIT abandons the op; a late mem_done must not ack.
      applyReset();
      prg_req = 1;
      waitGrant("x37 prg", 2'd2, 1'b0, PRG_ADDR, 1'b0);
      mem_ready = 1; @(posedge clk); #1; mem_ready = 0;
      checkOutput("x37 in wait", 32'(grant_id), 32'd2);
      #2 cpu_reset = 1;
      prg_req = 0;
      #1;
      checkOutput("x37 async valid", 32'(mem_valid), 32'd0);
      checkOutput("x37 async grant", 32'(grant_id), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      cpu_reset = 0;
      mem_done = 1; mem_rdata = 8'hEE;
      @(posedge clk); #1;
      mem_done = 0;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("x37 no ack%0d", i), 32'({host_ack, prg_ack, chr_ack}), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput("x37 rdata", 32'(rdata), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_sched.md
SDRAM_SCHED -- requirements
Module: sdram_sched

Interface
REQ-001 SHALL have parameter ADDR_BITS, 23, SDRAM byte address width.
REQ-002 SHALL have parameter HOST_MAX_WAIT, 4, lost grants before the host outranks PRG.
REQ-003 SHALL have clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have cpu_reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have chr_req / prg_req / host_req  in  1 each  request level, held until ack.
REQ-006 SHALL have chr_we / prg_we / host_we  in  1 each  1 = write, 0 = read.
REQ-007 SHALL have chr_addr / prg_addr / host_addr  in  ADDR_BITS each  byte address.
REQ-008 SHALL have chr_wdata / prg_wdata / host_wdata  in  8 each  write data.
REQ-009 SHALL have chr_ack / prg_ack / host_ack  out  1 each  one-cycle completion pulse.
REQ-010 SHALL have rdata  out  8  read data, valid while any ack is high.
REQ-011 SHALL have refresh_tick  in  1  one-cycle auto-refresh request.
REQ-012 SHALL have mem_valid / mem_we / mem_refresh  out  1 each  downstream command.
REQ-013 SHALL have mem_addr  out  ADDR_BITS  and mem_wdata  out  8  downstream command fields.
REQ-014 SHALL have mem_ready  in  1  command accepted; mem_done  in  1  operation complete; mem_rdata  in  8.
REQ-015 SHALL have grant_id  out  2  owner: 0 none, 1 CHR, 2 PRG, 3 host/refresh-free debug.
REQ-016 SHALL have refresh_overrun  out  1  sticky: refresh_tick lost at saturation.

Function
REQ-017 SHALL implement FSM IDLE, CMD, WAIT; one outstanding operation maximum.
REQ-018 SHALL keep refresh_pending, 2-bit counter: +1 per refresh_tick, -1 per completed refresh, saturating at 3; tick and completion in the same cycle leave it unchanged.
REQ-019 SHALL set refresh_overrun when refresh_tick arrives with refresh_pending = 3.
REQ-020 SHALL select in IDLE, highest first: refresh if pending >= 2; CHR; refresh if pending = 1; host if host_wait >= HOST_MAX_WAIT; PRG; host.
REQ-021 SHALL increment host_wait (saturating) on each CHR/PRG grant while host_req is high, and clear it on host grant.
REQ-022 SHALL, on grant in IDLE cycle N, register mem_addr/mem_we/mem_wdata/mem_refresh, set grant_id, assert mem_valid from N+1, enter CMD.
REQ-023 SHALL hold mem_valid and all mem_* fields stable in CMD until mem_valid && mem_ready, then drop mem_valid next cycle and enter WAIT.
REQ-024 SHALL for refresh drive mem_refresh=1, mem_we=0, mem_addr=0 and assert no ack.
REQ-025 SHALL, on mem_done in WAIT, register rdata <= mem_rdata, pulse the owner's ack for exactly one cycle, clear grant_id, return to IDLE.
REQ-026 SHALL ignore the just-acked requester's req in the IDLE cycle coincident with its ack.
REQ-027 SHALL treat req dropped before grant as withdrawn; req dropped after grant still completes and acks.
REQ-028 SHALL ignore mem_done outside WAIT and mem_ready outside CMD.
REQ-029 SHALL never assert more than one ack in a cycle.

Reset
REQ-030 SHALL on cpu_reset immediately force IDLE, mem_valid=0, all acks=0, grant_id=0, mem_* fields=0, rdata=0, refresh_pending=0, host_wait=0, refresh_overrun=0.
REQ-031 SHALL, on reset mid-operation, abandon the operation with no ack after release.

Verification
REQ-032 SHALL verify: prg_req read 0x001234, mem_ready same cycle as mem_valid, mem_done 3 cycles later with mem_rdata 0xA5 -> mem_valid at N+1 only, prg_ack one pulse, rdata=0xA5.
REQ-033 SHALL verify: chr_req and prg_req rise same cycle -> CHR granted first (grant_id=1), PRG granted after chr_ack.
REQ-034 SHALL verify: host_req held while CHR/PRG requests continuously -> after 4 lost grants host granted ahead of PRG, host_wait cleared.
REQ-035 SHALL verify: two refresh_ticks while CHR busy -> next grant is refresh (mem_refresh=1) ahead of pending CHR; pending returns 0 after two completions, no ack.
REQ-036 SHALL verify: four refresh_ticks with mem_ready held low -> pending=3, refresh_overrun=1.
REQ-037 SHALL verify: cpu_reset asserted in WAIT -> mem_valid=0, grant_id=0 same cycle; mem_done after release produces no ack.
